// File: rtl/bram_responder.sv
// bram_responder: single-port block-RAM target for the RAM test/LED initiator.
//
// Behaviour:
//   - After rst, every word is written to zero, one word per cycle (CLEAR).
//     ready stays 0 while this runs.
//   - After the clear, every cycle is an accepted access (IDLE):
//       wea=1 writes in_data to mem[addr]; wea=0 reads mem[addr].
//   - Each accepted access produces one result. out_valid pulses for 1 cycle
//     READ_LAT-1 edges after the accepting edge, and out_data carries the
//     result. A write returns its own in_data (write-first). out_data holds
//     its last valid value between results.
//   - wr_count and rd_count count accepted writes and reads, wrapping
//     modulo 2**CNT_W.
//
// Optional feature (macro RAM_PARITY_EN):
//   - Stores an even-parity bit with each word and checks it on every result.
//   - parity_err goes high with the bad result's out_valid and stays high
//     until rst.
//   - When the macro is undefined, parity_err is tied to 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   addr       word address
//   in_data    write data
//   wea        1 = write, 0 = read
//   out_data   read result
//   out_valid  1-cycle result strobe
//   ready      1 once the post-reset clear has finished
//   wr_count   accepted writes
//   rd_count   accepted reads
//   parity_err sticky parity mismatch flag
module bram_responder #(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wea,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              ready,
    output logic [CNT_W-1:0]  wr_count,
    output logic [CNT_W-1:0]  rd_count,
    output logic              parity_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
        $error("bram_responder: READ_LAT must be in 1..4");
    end

    typedef enum logic {
        StClear,
        StIdle
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              clr_we;
    logic              accept;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        clr_we    = 1'b0;
        accept    = 1'b0;
        ready     = 1'b0;
        unique case (state_q)
            StClear: begin
                clr_we    = 1'b1;
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == '1) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                ready  = 1'b1;
                accept = 1'b1;
            end
            default: state_d = StClear;
        endcase
        // The reset cycle neither clears nor accepts; the state register restarts anyway.
        if (rst) begin
            clr_we = 1'b0;
            accept = 1'b0;
        end
    end

    // ------------------------------------------------------------- memory
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_ptr_q] <= '0;
        end else if (accept && wea) begin
            mem[addr] <= in_data;
        end
    end

    // A write's result is its own data. A read sees the array before this
    // edge's update. That already includes any write from the previous cycle.
    logic [DATA_W-1:0] rd_word;
    assign rd_word = wea ? in_data : mem[addr];

    // ------------------------------------------------------ latency pipeline
    // Stage 0 loads at the accepting edge. Each further stage adds one cycle.
    // Data stages load only with a valid entry, so the last stage holds the
    // last result.
    logic              vld_q [READ_LAT];
    logic [DATA_W-1:0] dat_q [READ_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                vld_q[i] <= 1'b0;
                dat_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= accept;
            if (accept) begin
                dat_q[0] <= rd_word;
            end
            for (int i = 1; i < READ_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                if (vld_q[i-1]) begin
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end
    end

    assign out_valid = vld_q[READ_LAT-1];
    assign out_data  = dat_q[READ_LAT-1];

    // ----------------------------------------------------------- counters
    logic [CNT_W-1:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else if (accept) begin
            if (wea) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
            end else begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;

    // ------------------------------------------------------------- parity
`ifdef RAM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_q   [READ_LAT];
    logic err_q;
    logic par_mismatch;

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_ptr_q] <= 1'b0;
        end else if (accept && wea) begin
            par_mem[addr] <= ^in_data;
        end
    end

    // The stored bit travels with the data. The check happens at the output.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                par_q[i] <= 1'b0;
            end
        end else begin
            if (accept) begin
                par_q[0] <= wea ? ^in_data : par_mem[addr];
            end
            for (int i = 1; i < READ_LAT; i++) begin
                if (vld_q[i-1]) begin
                    par_q[i] <= par_q[i-1];
                end
            end
        end
    end

    assign par_mismatch = out_valid && ((^out_data) != par_q[READ_LAT-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (par_mismatch) begin
            err_q <= 1'b1;
        end
    end

    assign parity_err = err_q | par_mismatch;
`else
    assign parity_err = 1'b0;
`endif

endmodule
